// File: rtl/add_serial_pkg.sv
// Shared encodings for the digit-serial adder/subtractor: FSM states and operation modes.
package add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_serial_fa_cell.sv
// One-bit full adder cell; chained DIGIT times inside add_serial.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/add_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a full-adder chain with a
// registered carry; results are held from done until the next accepted start.
module add_serial
  import add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic [1:0]       state_o
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Handshake: start is accepted only in IDLE or DONE (operands captured on that edge);
  // busy is high for the NDIG RUN cycles; done pulses for one cycle with s/co/ovf valid.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] a_dig, b_dig, sum_dig;
  logic [DIGIT:0]   c_chain;
  logic             capture;

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (k_q == CW'(k)) begin
        a_dig = a_q[k*DIGIT +: DIGIT];
        b_dig = b_q[k*DIGIT +: DIGIT];
      end
    end
  end

  assign c_chain[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    fa_cell u_fa (
      .a_i  (a_dig[i]),
      .b_i  (b_dig[i]),
      .ci_i (c_chain[i]),
      .s_o  (sum_dig[i]),
      .co_o (c_chain[i+1])
    );
  end

  assign capture = start && (state_q != ST_RUN);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        for (int k = 0; k < NDIG; k++) begin
          if (k_q == CW'(k)) s_d[k*DIGIT +: DIGIT] = sum_dig;
        end
        carry_d = c_chain[DIGIT];
        co_d    = c_chain[DIGIT];
        // Carry into vs. out of the top cell; only meaningful on the final digit.
        ovf_d   = c_chain[DIGIT] ^ c_chain[DIGIT-1];
        k_d     = k_q + CW'(1);
        if (k_q == CW'(NDIG - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Subtraction is a + ~b + ~ci, so only the capture differs between modes.
    if (capture) begin
      a_d     = a;
      b_d     = (mode == MODE_SUB) ? ~b : b;
      carry_d = (mode == MODE_SUB) ? ~ci : ci;
      k_d     = '0;
      s_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign s       = s_q;
  assign co      = co_q;
  assign ovf     = ovf_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_add_serial.sv
// Bench for add_serial: four instances (DIGIT = 1, 2, 4, 8) plus a standalone fa_cell.
module tb_add_serial;
  import add_pkg::*;

  localparam int W  = 8;
  localparam int ND = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [ND-1:0] start, mode, ci;
  logic [W-1:0]  a_in [ND];
  logic [W-1:0]  b_in [ND];
  logic [ND-1:0] busy, done, co, ovf;
  logic [W-1:0]  s_out [ND];
  logic [1:0]    st [ND];

  logic fa_a, fa_b, fa_ci, fa_s, fa_co;

  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];   // {co, ovf, s}

  for (genvar g = 0; g < ND; g++) begin : g_dut
    add_serial #(.WIDTH(W), .DIGIT(1 << g)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start[g]),
      .mode    (mode[g]),
      .a       (a_in[g]),
      .b       (b_in[g]),
      .ci      (ci[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .s       (s_out[g]),
      .co      (co[g]),
      .ovf     (ovf[g]),
      .state_o (st[g])
    );
  end

  fa_cell u_fa (
    .a_i  (fa_a),
    .b_i  (fa_b),
    .ci_i (fa_ci),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(bit m, logic [W-1:0] av, logic [W-1:0] bv, bit c);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   full;
    logic         v;
    bb   = m ? ~bv : bv;
    cc   = m ? ~c : c;
    full = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, cc};
    v    = (av[W-1] == bb[W-1]) && (full[W-1] != av[W-1]);
    return {full[W], v, full[W-1:0]};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic scramble(int d);
    a_in[d] = W'($urandom);
    b_in[d] = W'($urandom);
    mode[d] = 1'($urandom_range(0, 1));
    ci[d]   = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts at a negedge, returns at the negedge of the DONE cycle.
  task automatic do_op(int d, bit m, logic [W-1:0] av, logic [W-1:0] bv, bit c, int pulse_at);
    int edges;
    int busy_cnt;
    int nd;
    logic [W+1:0] e;
    nd       = W >> d;
    start[d] = 1'b1;
    mode[d]  = m;
    a_in[d]  = av;
    b_in[d]  = bv;
    ci[d]    = c;
    exp_q.push_back(model(m, av, bv, c));
    @(posedge clk);
    edges    = 1;
    busy_cnt = 0;
    @(negedge clk);
    start[d] = 1'b0;
    scramble(d);
    while (!done[d] && edges < 4 * W) begin
      if (busy[d]) busy_cnt++;
      if (pulse_at != 0 && busy_cnt == pulse_at) begin
        start[d] = 1'b1;
        scramble(d);
      end else begin
        start[d] = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start[d] = 1'b0;
    check("done_seen", 32'(done[d]), 32'd1);
    check("latency", 32'(edges), 32'(nd + 1));
    check("busy_cycles", 32'(busy_cnt), 32'(nd));
    e = exp_q.pop_front();
    check("s", 32'(s_out[d]), 32'(e[W-1:0]));
    check("co", 32'(co[d]), 32'(e[W+1]));
    check("ovf", 32'(ovf[d]), 32'(e[W]));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst   = 1'b1;
    start = '0;
    mode  = '0;
    ci    = '0;
    for (int d = 0; d < ND; d++) begin
      a_in[d] = '0;
      b_in[d] = '0;
    end
    fa_a = 1'b0; fa_b = 1'b0; fa_ci = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < ND; d++) begin
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_done", 32'(done[d]), 32'd0);
      check("rst_s", 32'(s_out[d]), 32'd0);
      check("rst_co", 32'(co[d]), 32'd0);
      check("rst_ovf", 32'(ovf[d]), 32'd0);
      check("rst_state", 32'(st[d]), 32'(ST_IDLE));
    end

    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      fa_a = vv[2]; fa_b = vv[1]; fa_ci = vv[0];
      #1;
      check("fa_cell", 32'({fa_co, fa_s}), 32'(vv[2]) + 32'(vv[1]) + 32'(vv[0]));
    end
    @(negedge clk);

    do_op(0, MODE_ADD, 8'h7F, 8'h01, 1'b0, 0);
    idle();
    do_op(0, MODE_ADD, 8'hFF, 8'h01, 1'b0, 0);
    do_op(0, MODE_SUB, 8'h05, 8'h07, 1'b0, 0);
    idle();
    do_op(2, MODE_ADD, 8'h3C, 8'h4A, 1'b1, 0);
    idle();
    do_op(2, MODE_SUB, 8'h80, 8'h01, 1'b0, 0);
    idle();
    do_op(3, MODE_ADD, 8'hC8, 8'h9A, 1'b1, 0);
    idle();
    do_op(1, MODE_SUB, 8'h00, 8'h00, 1'b1, 0);
    idle();

    do_op(0, MODE_ADD, 8'h12, 8'h34, 1'b0, 3);
    idle();

    // Reset together with start while digit 3 is in flight.
    start[0] = 1'b1; mode[0] = MODE_ADD; a_in[0] = 8'hFF; b_in[0] = 8'hFF; ci[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) idle();
    rst = 1'b1;
    start[0] = 1'b1; a_in[0] = 8'hAA; b_in[0] = 8'h11;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start[0] = 1'b0;
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_done", 32'(done[0]), 32'd0);
    check("mid_rst_s", 32'(s_out[0]), 32'd0);
    check("mid_rst_state", 32'(st[0]), 32'(ST_IDLE));
    idle();
    check("post_rst_idle", 32'(st[0]), 32'(ST_IDLE));
    do_op(0, MODE_ADD, 8'h55, 8'h22, 1'b1, 0);
    idle();

    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 1000; i++) begin
        do_op(d, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
              1'($urandom_range(0, 1)), 0);
        if ($urandom_range(0, 1) == 1) idle();
      end
      idle();
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
